// File: rtl/mips8_mem_alu_unit.sv
// Memory-and-execute block of the 8-bit MIPS-style core: program ROM with a load
// port, async-read/sync-write data RAM, and the 2-bit-controlled ALU with zero flag.
module mips8_mem_alu_unit #(
    parameter int IM_DATA_W = 8,
    parameter int IM_ADDR_W = 8,
    parameter int DM_DATA_W = 8,
    parameter int DM_ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 im_cs_n,
    input  logic                 im_oe,
    input  logic [IM_ADDR_W-1:0] im_addr,
    output logic [IM_DATA_W-1:0] im_rdata,
    input  logic                 im_we,
    input  logic [IM_ADDR_W-1:0] im_waddr,
    input  logic [IM_DATA_W-1:0] im_wdata,
    input  logic [1:0]           alu_ctrl,
    input  logic [DM_DATA_W-1:0] alu_a,
    input  logic [DM_DATA_W-1:0] alu_b,
    output logic [DM_DATA_W-1:0] alu_y,
    output logic                 alu_zero,
    input  logic                 dm_we,
    input  logic [DM_ADDR_W-1:0] dm_addr,
    input  logic [DM_DATA_W-1:0] dm_wdata,
    output logic [DM_DATA_W-1:0] dm_rdata
);

    localparam int IM_DEPTH = 1 << IM_ADDR_W;
    localparam int DM_DEPTH = 1 << DM_ADDR_W;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

    logic [IM_DATA_W-1:0] im_mem_q [IM_DEPTH];
    logic [IM_DATA_W-1:0] im_mem_d [IM_DEPTH];
    logic [DM_DATA_W-1:0] dm_mem_q [DM_DEPTH];
    logic [DM_DATA_W-1:0] dm_mem_d [DM_DEPTH];

    always_comb begin
        im_mem_d = im_mem_q;
        if (im_we) begin
            im_mem_d[im_waddr] = im_wdata;
        end
    end

    always_comb begin
        dm_mem_d = dm_mem_q;
        if (dm_we) begin
            dm_mem_d[dm_addr] = dm_wdata;
        end
    end

    // Both arrays clear the moment reset asserts, so a write on an edge seen
    // during reset never lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < IM_DEPTH; i++) begin
                im_mem_q[i] <= '0;
            end
            for (int j = 0; j < DM_DEPTH; j++) begin
                dm_mem_q[j] <= '0;
            end
        end else begin
            im_mem_q <= im_mem_d;
            dm_mem_q <= dm_mem_d;
        end
    end

    always_comb begin
        im_rdata = '0;
        if (!im_cs_n && im_oe) begin
            im_rdata = im_mem_q[im_addr];
        end
    end

    assign dm_rdata = dm_mem_q[dm_addr];

    // Carry and overflow fall off the top of the operand width.
    always_comb begin
        alu_y = '0;
        case (alu_op_e'(alu_ctrl))
            ALU_ADD: alu_y = alu_a + alu_b;
            ALU_SUB: alu_y = alu_a - alu_b;
            ALU_AND: alu_y = alu_a & alu_b;
            ALU_OR:  alu_y = alu_a | alu_b;
            default: alu_y = '0;
        endcase
    end

    assign alu_zero = (alu_y == '0);

endmodule

// File: tb/tb_mips8_mem_alu_unit.sv
// Self-checking bench for mips8_mem_alu_unit: directed plan cases followed by
// randomized traffic compared against an array-based reference model.
module tb_mips8_mem_alu_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       im_cs_n;
    logic       im_oe;
    logic [7:0] im_addr;
    logic [7:0] im_rdata;
    logic       im_we;
    logic [7:0] im_waddr;
    logic [7:0] im_wdata;
    logic [1:0] alu_ctrl;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_y;
    logic       alu_zero;
    logic       dm_we;
    logic [7:0] dm_addr;
    logic [7:0] dm_wdata;
    logic [7:0] dm_rdata;

    int errorCount = 0;
    int checkCount = 0;

    int imModel [256];
    int dmModel [256];

    mips8_mem_alu_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .im_cs_n  (im_cs_n),
        .im_oe    (im_oe),
        .im_addr  (im_addr),
        .im_rdata (im_rdata),
        .im_we    (im_we),
        .im_waddr (im_waddr),
        .im_wdata (im_wdata),
        .alu_ctrl (alu_ctrl),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_y    (alu_y),
        .alu_zero (alu_zero),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic int aluModel(input int op, input int a, input int b);
        case (op)
            0:       return (a + b) % 256;
            1:       return (a - b + 256) % 256;
            2:       return a & b;
            default: return a | b;
        endcase
    endfunction

    task automatic clearModel();
        for (int i = 0; i < 256; i++) begin
            imModel[i] = 0;
            dmModel[i] = 0;
        end
    endtask

    task automatic applyStimulus();
        im_cs_n  = ($urandom_range(0, 3) == 0);
        im_oe    = ($urandom_range(0, 3) != 0);
        im_addr  = 8'($urandom_range(0, 15));
        im_we    = ($urandom_range(0, 1) == 1);
        im_waddr = 8'($urandom_range(0, 15));
        im_wdata = 8'($urandom);
        alu_ctrl = 2'($urandom);
        alu_a    = 8'($urandom);
        alu_b    = ($urandom_range(0, 3) == 0) ? alu_a : 8'($urandom);
        dm_we    = ($urandom_range(0, 1) == 1);
        dm_addr  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom);
        dm_wdata = 8'($urandom);
    endtask

    task automatic aluCase(input string tag, input logic [1:0] op, input logic [7:0] a,
                           input logic [7:0] b, input int expY, input int expZ);
        alu_ctrl = op;
        alu_a    = a;
        alu_b    = b;
        #1;
        checkOutput({tag, "_y"}, alu_y, expY);
        checkOutput({tag, "_zero"}, alu_zero, expZ);
    endtask

    initial begin
        int expIm;
        rst_n = 1'b0; im_cs_n = 1'b1; im_oe = 1'b0; im_addr = '0; im_we = 1'b0;
        im_waddr = '0; im_wdata = '0; alu_ctrl = '0; alu_a = '0; alu_b = '0;
        dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;

        #12;
        im_cs_n = 1'b0; im_oe = 1'b1; im_addr = 8'h05; dm_addr = 8'h05;
        #1;
        checkOutput("reset_im05", im_rdata, 8'h00);
        checkOutput("reset_dm05", dm_rdata, 8'h00);

        @(negedge clk);
        rst_n = 1'b1;

        // Program load and read-enable gating
        @(negedge clk);
        im_we = 1'b1; im_waddr = 8'h03; im_wdata = 8'hA7; im_addr = 8'h03;
        @(posedge clk); #1;
        im_we = 1'b0;
        #1;
        checkOutput("im_load_read", im_rdata, 8'hA7);
        im_oe = 1'b0; #1;
        checkOutput("im_oe_low", im_rdata, 8'h00);
        im_oe = 1'b1; im_cs_n = 1'b1; #1;
        checkOutput("im_cs_high", im_rdata, 8'h00);
        im_cs_n = 1'b0;

        aluCase("add",      2'b00, 8'h05, 8'h03, 8'h08, 0);
        aluCase("sub",      2'b01, 8'h05, 8'h03, 8'h02, 0);
        aluCase("and",      2'b10, 8'h05, 8'h03, 8'h01, 0);
        aluCase("or",       2'b11, 8'h05, 8'h03, 8'h07, 0);
        aluCase("add_wrap", 2'b00, 8'hFF, 8'h01, 8'h00, 1);
        aluCase("sub_wrap", 2'b01, 8'h00, 8'h01, 8'hFF, 0);
        aluCase("sub_eq",   2'b01, 8'h3C, 8'h3C, 8'h00, 1);

        // Read-during-write: old value before the edge, new value after
        @(negedge clk);
        dm_we = 1'b1; dm_addr = 8'h10; dm_wdata = 8'h5A;
        #1;
        checkOutput("dm_rdw_before", dm_rdata, 8'h00);
        @(posedge clk); #1;
        checkOutput("dm_rdw_after", dm_rdata, 8'h5A);
        @(negedge clk);
        dm_addr = 8'h11; dm_wdata = 8'h33;
        @(posedge clk); #1;
        dm_we = 1'b0;
        dm_addr = 8'h10; #1;
        checkOutput("dm_10_kept", dm_rdata, 8'h5A);
        dm_addr = 8'h11; #1;
        checkOutput("dm_11_written", dm_rdata, 8'h33);

        // Asynchronous reset clears without an edge; writes during reset drop
        @(negedge clk);
        dm_we = 1'b1; dm_addr = 8'h20; dm_wdata = 8'h77;
        @(posedge clk); #1;
        dm_we = 1'b0; #1;
        checkOutput("dm_20_written", dm_rdata, 8'h77);
        @(negedge clk); #2;
        rst_n = 1'b0; #1;
        checkOutput("dm_async_clear", dm_rdata, 8'h00);
        im_addr = 8'h03; #1;
        checkOutput("im_async_clear", im_rdata, 8'h00);
        dm_we = 1'b1; dm_wdata = 8'h99; im_we = 1'b1; im_waddr = 8'h03; im_wdata = 8'h5C;
        @(posedge clk); #1;
        checkOutput("dm_write_in_reset", dm_rdata, 8'h00);
        checkOutput("im_write_in_reset", im_rdata, 8'h00);
        @(negedge clk);
        rst_n = 1'b1; dm_wdata = 8'h44; im_wdata = 8'hC5;
        @(posedge clk); #1;
        checkOutput("dm_first_write", dm_rdata, 8'h44);
        checkOutput("im_first_write", im_rdata, 8'hC5);
        dm_we = 1'b0; im_we = 1'b0;

        // Randomized traffic against the reference model, starting from reset
        @(negedge clk);
        rst_n = 1'b0; #1;
        clearModel();
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            applyStimulus();
            #1;
            expIm = (!im_cs_n && im_oe) ? imModel[im_addr] : 0;
            checkOutput("rnd_alu_y", alu_y, aluModel(alu_ctrl, alu_a, alu_b));
            checkOutput("rnd_alu_zero", alu_zero, (aluModel(alu_ctrl, alu_a, alu_b) == 0) ? 1 : 0);
            checkOutput("rnd_im_rdata", im_rdata, expIm);
            checkOutput("rnd_dm_rdata", dm_rdata, dmModel[dm_addr]);
            if (im_we) imModel[im_waddr] = im_wdata;
            if (dm_we) dmModel[dm_addr] = dm_wdata;
        end
        @(posedge clk); #1;
        im_we = 1'b0; dm_we = 1'b0; im_cs_n = 1'b0; im_oe = 1'b1;
        for (int a = 0; a < 16; a++) begin
            im_addr = 8'(a); dm_addr = 8'(a); #1;
            checkOutput("final_im", im_rdata, imModel[a]);
            checkOutput("final_dm", dm_rdata, dmModel[a]);
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
